// File: rtl/run_length_ctrl.sv
// Run-length sequencer for a loadable up counter: loads ~length, paces increments
// with a prescaler, and emits a one-cycle done pulse once the counter's RCO is seen.
module run_length_ctrl #(
  parameter int n   = 8,
  parameter int DIV = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic         abort,
  input  logic [n-1:0] length,
  input  logic         cnt_rco,
  output logic         cnt_ld,
  output logic [n-1:0] cnt_D,
  output logic         cnt_up,
  output logic         tick,
  output logic         busy,
  output logic         done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FINISH} state_t;

  state_t         state, state_nx;
  logic [n-1:0]   len_reg;
  logic [PW-1:0]  pre, pre_nx;
  logic           len_ld;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      len_reg <= '0;
      pre     <= '0;
    end else begin
      state <= state_nx;
      pre   <= pre_nx;
      if (len_ld) len_reg <= length;
    end
  end

  always_comb begin
    state_nx = state;
    pre_nx   = pre;
    len_ld   = 1'b0;
    cnt_ld   = 1'b0;
    cnt_up   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          len_ld   = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        cnt_ld   = 1'b1;
        busy     = 1'b1;
        pre_nx   = '0;
        state_nx = abort ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        // abort beats RCO, RCO beats counting: no increment once the count is complete
        if (abort) begin
          state_nx = IDLE;
        end else if (cnt_rco) begin
          state_nx = FINISH;
        end else begin
          cnt_up = (pre == PRE_MAX);
          pre_nx = (pre == PRE_MAX) ? '0 : pre + 1'b1;
        end
      end
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ~L counts up to all-ones in exactly L increments
  assign cnt_D = ~len_reg;
  assign tick  = cnt_up;

endmodule
